// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin issue of two ALU reservation stations onto one
// shared combinational Alu, with a single-entry result register drained by a
// valid/ready handshake toward writeback.
//
// Ports:
//   clk_i, reset_i (sync, active-high), flush_i (kills held result and grant)
//   req{0,1}_valid_i/op_i/in1_i/in2_i/tag_i : requester operation and rename tag
//   req{0,1}_grant_o                        : combinational accept strobe
//   alu_op_o/alu_in1_o/alu_in2_o            : combinational drive to the Alu
//   alu_out_i                               : Alu result
//   result_valid_o/data_o/tag_o             : registered result
//   result_ready_i                          : consumer accepts result
module alu_issue_arbiter #(
    parameter int unsigned DATA_LEN     = 32,
    parameter int unsigned ALU_OP_WIDTH = 4,
    parameter int unsigned RRF_SEL      = 6
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    flush_i,

    input  logic                    req0_valid_i,
    input  logic [ALU_OP_WIDTH-1:0] req0_op_i,
    input  logic [DATA_LEN-1:0]     req0_in1_i,
    input  logic [DATA_LEN-1:0]     req0_in2_i,
    input  logic [RRF_SEL-1:0]      req0_tag_i,
    output logic                    req0_grant_o,

    input  logic                    req1_valid_i,
    input  logic [ALU_OP_WIDTH-1:0] req1_op_i,
    input  logic [DATA_LEN-1:0]     req1_in1_i,
    input  logic [DATA_LEN-1:0]     req1_in2_i,
    input  logic [RRF_SEL-1:0]      req1_tag_i,
    output logic                    req1_grant_o,

    output logic [ALU_OP_WIDTH-1:0] alu_op_o,
    output logic [DATA_LEN-1:0]     alu_in1_o,
    output logic [DATA_LEN-1:0]     alu_in2_o,
    input  logic [DATA_LEN-1:0]     alu_out_i,

    output logic                    result_valid_o,
    output logic [DATA_LEN-1:0]     result_data_o,
    output logic [RRF_SEL-1:0]      result_tag_o,
    input  logic                    result_ready_i
);

    // last_grant_q: index of the requester granted most recently (1 after reset
    // so RS0 wins the first tie).
    logic                result_valid_q, result_valid_d;
    logic [DATA_LEN-1:0] result_data_q,  result_data_d;
    logic [RRF_SEL-1:0]  result_tag_q,   result_tag_d;
    logic                last_grant_q,   last_grant_d;

    logic slot_free;
    logic can_grant;
    logic gnt0, gnt1;
    logic sel1;

    // Arbitration and Alu operand steering.
    always_comb begin
        slot_free = !result_valid_q || result_ready_i;
        can_grant = !reset_i && !flush_i && slot_free;
        // On a tie RS1 wins only if RS0 was granted last.
        gnt0 = can_grant && req0_valid_i && (!req1_valid_i || last_grant_q);
        gnt1 = can_grant && req1_valid_i && (!req0_valid_i || !last_grant_q);
        // Idle cycles still present RS0 when it is valid; the result is dropped.
        sel1 = gnt1 || (!gnt0 && !req0_valid_i);

        req0_grant_o = gnt0;
        req1_grant_o = gnt1;
        alu_op_o     = sel1 ? req1_op_i  : req0_op_i;
        alu_in1_o    = sel1 ? req1_in1_i : req0_in1_i;
        alu_in2_o    = sel1 ? req1_in2_i : req0_in2_i;
    end

    // Next-state for the result register: reset > flush > capture > drain > hold.
    always_comb begin
        result_valid_d = result_valid_q;
        result_data_d  = result_data_q;
        result_tag_d   = result_tag_q;
        last_grant_d   = last_grant_q;

        if (reset_i) begin
            result_valid_d = 1'b0;
            result_data_d  = '0;
            result_tag_d   = '0;
            last_grant_d   = 1'b1;
        end else if (flush_i) begin
            result_valid_d = 1'b0;
        end else if (gnt0 || gnt1) begin
            result_valid_d = 1'b1;
            result_data_d  = alu_out_i;
            result_tag_d   = gnt1 ? req1_tag_i : req0_tag_i;
            last_grant_d   = gnt1;
        end else if (result_valid_q && result_ready_i) begin
            result_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        result_valid_q <= result_valid_d;
        result_data_q  <= result_data_d;
        result_tag_q   <= result_tag_d;
        last_grant_q   <= last_grant_d;
    end

    assign result_valid_o = result_valid_q;
    assign result_data_o  = result_data_q;
    assign result_tag_o   = result_tag_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: directed steps followed by a randomized phase,
// every cycle compared against a transaction-level reference model.
module tb_alu_issue_arbiter;

    localparam int unsigned DL = 32;
    localparam int unsigned OW = 4;
    localparam int unsigned TW = 6;

    localparam logic [OW-1:0] OP_ADD = 4'd0;
    localparam logic [OW-1:0] OP_SUB = 4'd1;
    localparam logic [OW-1:0] OP_SLT = 4'd2;
    localparam logic [OW-1:0] OP_XOR = 4'd4;
    localparam logic [OW-1:0] OP_SRA = 4'd5;
    localparam logic [OW-1:0] OP_BAD = 4'd15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, fl, rdy;
    logic          v   [2];
    logic [OW-1:0] op  [2];
    logic [DL-1:0] a   [2];
    logic [DL-1:0] b   [2];
    logic [TW-1:0] tg  [2];

    logic          gnt0, gnt1;
    logic [OW-1:0] alu_op;
    logic [DL-1:0] alu_in1, alu_in2, alu_out;
    logic          res_valid;
    logic [DL-1:0] res_data;
    logic [TW-1:0] res_tag;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic          m_valid;
    logic [DL-1:0] m_data;
    logic [TW-1:0] m_tag;
    int            m_prefer;   // requester that wins the next tie

    function automatic logic [DL-1:0] alu_ref(input logic [OW-1:0] o,
                                              input logic [DL-1:0] x,
                                              input logic [DL-1:0] y);
        case (o)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_SLT:  return ($signed(x) < $signed(y)) ? DL'(1) : DL'(0);
            OP_XOR:  return x ^ y;
            OP_SRA:  return DL'($signed(x) >>> y[4:0]);
            default: return '0;
        endcase
    endfunction

    assign alu_out = alu_ref(alu_op, alu_in1, alu_in2);

    alu_issue_arbiter #(.DATA_LEN(DL), .ALU_OP_WIDTH(OW), .RRF_SEL(TW)) dut (
        .clk_i          (clk),
        .reset_i        (rst),
        .flush_i        (fl),
        .req0_valid_i   (v[0]),
        .req0_op_i      (op[0]),
        .req0_in1_i     (a[0]),
        .req0_in2_i     (b[0]),
        .req0_tag_i     (tg[0]),
        .req0_grant_o   (gnt0),
        .req1_valid_i   (v[1]),
        .req1_op_i      (op[1]),
        .req1_in1_i     (a[1]),
        .req1_in2_i     (b[1]),
        .req1_tag_i     (tg[1]),
        .req1_grant_o   (gnt1),
        .alu_op_o       (alu_op),
        .alu_in1_o      (alu_in1),
        .alu_in2_o      (alu_in2),
        .alu_out_i      (alu_out),
        .result_valid_o (res_valid),
        .result_data_o  (res_data),
        .result_tag_o   (res_tag),
        .result_ready_i (rdy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic vv, input logic [OW-1:0] o,
                           input logic [DL-1:0] x, input logic [DL-1:0] y,
                           input logic [TW-1:0] t);
        v[i] = vv; op[i] = o; a[i] = x; b[i] = y; tg[i] = t;
    endtask

    // One clock: inputs are already set; check the combinational side, step the
    // model on the edge, then check the registered side.
    task automatic cycle(output int g);
        int src;
        #1;
        g = -1;
        if (!rst && !fl && (!m_valid || rdy)) begin
            if (v[0] && v[1]) g = m_prefer;
            else if (v[0])    g = 0;
            else if (v[1])    g = 1;
        end
        src = (g >= 0) ? g : (v[0] ? 0 : 1);
        chk("grant0", 64'(gnt0), 64'(g == 0));
        chk("grant1", 64'(gnt1), 64'(g == 1));
        chk("alu_op",  64'(alu_op),  64'(op[src]));
        chk("alu_in1", 64'(alu_in1), 64'(a[src]));
        chk("alu_in2", 64'(alu_in2), 64'(b[src]));
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_tag = '0; m_prefer = 0;
        end else if (fl) begin
            m_valid = 1'b0;
        end else if (g >= 0) begin
            m_valid  = 1'b1;
            m_data   = alu_ref(op[g], a[g], b[g]);
            m_tag    = tg[g];
            m_prefer = 1 - g;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        #1;
        chk("res_valid", 64'(res_valid), 64'(m_valid));
        chk("res_data",  64'(res_data),  64'(m_data));
        chk("res_tag",   64'(res_tag),   64'(m_tag));
        @(negedge clk);
    endtask

    initial begin
        int g;
        logic [OW-1:0] ops [6];
        ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_SLT;
        ops[3] = OP_XOR; ops[4] = OP_SRA; ops[5] = OP_BAD;
        m_valid = 1'b0; m_data = '0; m_tag = '0; m_prefer = 0;
        rst = 1'b1; fl = 1'b0; rdy = 1'b1;
        set_req(0, 1'b0, '0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0, '0);
        @(negedge clk);

        // Reset clears everything.
        cycle(g);
        chk("reset_valid", 64'(res_valid), 64'(0));
        rst = 1'b0;

        // Single ADD from RS0.
        set_req(0, 1'b1, OP_ADD, 32'd5, 32'd7, 6'd3);
        cycle(g);
        chk("add_grant", 64'(g), 64'(0));
        chk("add_data", 64'(res_data), 64'(12));
        chk("add_tag",  64'(res_tag),  64'(3));

        // Fresh reset so RS0 wins the first tie, then both valid for 4 cycles.
        set_req(0, 1'b0, '0, '0, '0, '0);
        rst = 1'b1; cycle(g); rst = 1'b0;
        set_req(0, 1'b1, OP_SUB, 32'd10, 32'd3, 6'd1);
        set_req(1, 1'b1, OP_XOR, 32'hF0, 32'h0F, 6'd2);
        for (int i = 0; i < 4; i++) begin
            cycle(g);
            chk("rr_grant", 64'(g), 64'(i % 2));
            chk("rr_data",  64'(res_data), (i % 2 == 0) ? 64'd7 : 64'hFF);
            chk("rr_valid", 64'(res_valid), 64'(1));
        end

        // Backpressure: held result, no grant for 3 cycles, then RS1 issues SLT.
        set_req(0, 1'b0, '0, '0, '0, '0);
        set_req(1, 1'b1, OP_SLT, 32'hFFFF_FFFF, 32'd1, 6'd5);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(g);
            chk("bp_nogrant", 64'(g), 64'(-1));
            chk("bp_hold",    64'(res_data), 64'hFF);
        end
        rdy = 1'b1;
        cycle(g);
        chk("bp_grant", 64'(g), 64'(1));
        chk("slt_data", 64'(res_data), 64'(1));
        set_req(1, 1'b0, '0, '0, '0, '0);

        // Flush kills the held result and blocks the grant.
        set_req(0, 1'b1, OP_ADD, 32'd1, 32'd2, 6'd7);
        fl = 1'b1; rdy = 1'b0;
        cycle(g);
        chk("flush_nogrant", 64'(g), 64'(-1));
        chk("flush_valid",   64'(res_valid), 64'(0));
        fl = 1'b0;
        cycle(g);
        chk("post_flush_grant", 64'(g), 64'(0));
        rdy = 1'b1;

        // Reset mid-stream with both valid.
        set_req(1, 1'b1, OP_XOR, 32'h1234, 32'h00FF, 6'd4);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle(g);
            chk("rst_nogrant", 64'(g), 64'(-1));
            chk("rst_data",    64'(res_data), 64'(0));
        end
        rst = 1'b0;
        cycle(g);
        chk("post_rst_grant", 64'(g), 64'(0));
        set_req(0, 1'b0, '0, '0, '0, '0);

        // RS1 alone, arithmetic right shift.
        set_req(1, 1'b1, OP_SRA, 32'h8000_0000, 32'd4, 6'd9);
        cycle(g);
        chk("sra_grant", 64'(g), 64'(1));
        chk("sra_data",  64'(res_data), 64'hF800_0000);
        chk("sra_tag",   64'(res_tag),  64'(9));
        set_req(1, 1'b0, '0, '0, '0, '0);

        // Randomized traffic; pending requests stay stable until granted.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!v[i] && ($urandom_range(0, 3) != 0))
                    set_req(i, 1'b1, ops[$urandom_range(0, 5)], $urandom(), $urandom(),
                            TW'($urandom()));
            end
            rdy = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 49) == 0);
            cycle(g);
            if (g >= 0) v[g] = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
